wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares the single physical-register write port between N execution lanes: alu, alu_ext, fpu, mem, subst/io, and so on.
- Each lane pulses done with a tag (pa_rd) and result (rd).
- A one-entry holding buffer per lane absorbs lanes that lose arbitration. Round-robin grant drives a registered write-back port to register_manage.
- Sits between the exec lanes and register_manage; replaces per-lane direct write_d_r driving.

Parameters:
- N_LANES, 4, number of requesting exec lanes (2..8).
- LEN_WORD, 32, result width.
- LEN_PREG_ADDR, 6, physical register tag width.
- LEN_LANE_IDX, 2, width of lane index; must satisfy 2**LEN_LANE_IDX >= N_LANES.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-high reset: value 1 at a rising clk edge resets the block.
- lane_done  in  N_LANES  per-lane one-cycle result-valid pulse.
- lane_pa_rd  in  N_LANES*LEN_PREG_ADDR  per-lane destination tag; lane i occupies bits [i*LEN_PREG_ADDR +: LEN_PREG_ADDR].
- lane_rd  in  N_LANES*LEN_WORD  per-lane result, packed the same way.
- lane_stall  out  N_LANES  registered; 1 = lane's holding buffer is full, lane must not assert done.
- wr_en  out  1  registered write strobe to register_manage.
- wr_pa  out  LEN_PREG_ADDR  registered write tag.
- wr_data  out  LEN_WORD  registered write data.
- wr_lane  out  LEN_LANE_IDX  registered index of the lane written.

Behaviour:
- Reset (rstn=1 at an edge):
  - all buf_valid=0; rr_ptr=0.
  - wr_en=0, wr_pa=0, wr_data=0, wr_lane=0.
  - lane_stall=0.
  - In-flight buffered results are discarded.
- Candidate for lane i in a cycle: buf_valid[i] ? buffered entry : (lane_done[i] ? incoming entry : none).
  - The buffered entry always has priority over a same-lane incoming entry, so per-lane order is preserved.
- Tag 0 is the hardwired-zero register. A candidate with pa_rd==0 is retired in the same cycle without requesting the port.
  - Such a buffered entry clears its buffer.
  - Such an incoming entry is not buffered.
- Arbitration: combinational round-robin over requesting candidates, starting at rr_ptr and searching upward with wrap from N_LANES-1 to 0.
  - On a grant to lane g: rr_ptr <= (g+1) mod N_LANES.
  - No request: rr_ptr holds.
- Write port: on the edge after a grant, wr_en=1 with wr_pa/wr_data/wr_lane from the granted candidate; otherwise wr_en=0 and the data outputs hold their last value.
  - Latency from done to wr_en is 1 cycle when granted immediately, 1+k cycles after k lost rounds.
- Buffer update for lane i, next cycle:
  - granted buffered entry and lane_done (tag≠0) → buffer loads incoming, stays valid.
  - granted buffered entry, no done → buffer clears.
  - granted incoming entry → buffer unchanged (empty).
  - ungranted incoming entry (tag≠0) with empty buffer → buffer loads it.
  - ungranted buffered entry → holds.
- lane_stall[i] = next buf_valid[i], registered. It is asserted the cycle after the buffer fills.
- lane_done[i] while buffer full and buffered entry not granted is a protocol violation. The incoming entry is dropped and the buffer keeps the old entry.
- Starvation bound: a buffered entry is written within N_LANES cycles.
- Throughput: one write per cycle sustained.

Optional Feature:
- Macro WB_ARB_ERR_CHECK_EN.
- Defined: adds output err (1 bit, sticky until reset) and err_lane (LEN_LANE_IDX, lane of the first violation).
  - err is set the cycle after a dropped lane_done.
  - err_lane is captured only on the first violation.
  - Both reset to 0.
- Undefined: ports absent, violations silently drop, no extra logic.

Decomposition:
- Shared package / include.vh holds LEN_WORD, LEN_PREG_ADDR, LEN_LANE_IDX and the packed write_d_r layout {valid, pa, data}, so wr_* packs via the existing pack_struct_write_d_r.
- One sub-module is natural: rr_arbiter (N requests plus pointer in; one-hot grant plus encoded index out; purely combinational).
- Per-lane buffers are a generate loop over temp_reg.

Test Plan:
- Single lane: lane 1 done, pa=5, rd=0xDEADBEEF → next cycle wr_en=1, wr_pa=5, wr_data=0xDEADBEEF, wr_lane=1; rr_ptr=2.
- All 4 lanes done together at rr_ptr=0, tags 1..4 → writes lanes 0,1,2,3 on 4 consecutive cycles. lane_stall[1..3] asserts next cycle and each deasserts the cycle after its entry is granted.
- Lane 2 buffered and done again on the cycle its buffer is granted (tag 9 then tag 10) → writes 9 then 10 in order; no stall gap; no drop.
- Lane 0 done with pa=0 while lane 3 done with pa=7 → only lane 3 written; lane 0 never stalls.
- Rotation: lanes 0 and 1 continuously requesting (done every cycle while not stalled) → grants alternate 0,1,0,1; neither waits more than 2 cycles.
- With WB_ARB_ERR_CHECK_EN: lane 3 done while lane_stall[3]=1 and lane 3 not granted → err=1, err_lane=3 next cycle; buffered entry still written later; rstn=1 clears err.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared widths and the packed write_d_r layout {valid, pa, data} used by the
// write-back arbiter and register_manage.
package wb_arbiter_pkg;

    localparam int WB_N_LANES       = 4;
    localparam int WB_LEN_WORD      = 32;
    localparam int WB_LEN_PREG_ADDR = 6;
    localparam int WB_LEN_LANE_IDX  = 2;

    typedef struct packed {
        logic                        valid;
        logic [WB_LEN_PREG_ADDR-1:0] pa;
        logic [WB_LEN_WORD-1:0]      data;
    } write_d_r_t;

    function automatic write_d_r_t pack_struct_write_d_r(
        input logic                        valid,
        input logic [WB_LEN_PREG_ADDR-1:0] pa,
        input logic [WB_LEN_WORD-1:0]      data
    );
        write_d_r_t w;
        w.valid = valid;
        w.pa    = pa;
        w.data  = data;
        return w;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr.sv
// Combinational round-robin picker: first request at or above ptr_i, wrapping
// from N-1 back to 0.
module wb_arbiter_rr #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    always_comb begin
        int unsigned j;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!vld_o && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
                vld_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter with a one-entry holding buffer per lane.
// Optional WB_ARB_ERR_CHECK_EN adds a sticky err/err_lane for dropped lane_done.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N_LANES       = WB_N_LANES,
    parameter int LEN_WORD      = WB_LEN_WORD,
    parameter int LEN_PREG_ADDR = WB_LEN_PREG_ADDR,
    parameter int LEN_LANE_IDX  = WB_LEN_LANE_IDX
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [N_LANES-1:0]                 lane_done,
    input  logic [N_LANES*LEN_PREG_ADDR-1:0]   lane_pa_rd,
    input  logic [N_LANES*LEN_WORD-1:0]        lane_rd,
    output logic [N_LANES-1:0]                 lane_stall,
    output logic                               wr_en,
    output logic [LEN_PREG_ADDR-1:0]           wr_pa,
    output logic [LEN_WORD-1:0]                wr_data,
    output logic [LEN_LANE_IDX-1:0]            wr_lane
`ifdef WB_ARB_ERR_CHECK_EN
    ,
    output logic                               err,
    output logic [LEN_LANE_IDX-1:0]            err_lane
`endif
);

    logic [N_LANES-1:0][LEN_PREG_ADDR-1:0] cand_pa;
    logic [N_LANES-1:0][LEN_WORD-1:0]      cand_data;
    logic [N_LANES-1:0]                    req, gnt;
    logic [LEN_LANE_IDX-1:0]               gnt_idx, rr_ptr_q, rr_ptr_d;
    logic                                  gnt_vld;
`ifdef WB_ARB_ERR_CHECK_EN
    logic [N_LANES-1:0]                    viol;
`endif

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        logic                     vld_q, vld_d;
        logic [LEN_PREG_ADDR-1:0] pa_q, pa_d, in_pa;
        logic [LEN_WORD-1:0]      data_q, data_d, in_data;
        logic                     retire;
        logic                     in_load;

        assign in_pa     = lane_pa_rd[i*LEN_PREG_ADDR +: LEN_PREG_ADDR];
        assign in_data   = lane_rd[i*LEN_WORD +: LEN_WORD];
        // Buffered entry always wins over a same-lane incoming one to keep order.
        assign cand_pa[i]   = vld_q ? pa_q : in_pa;
        assign cand_data[i] = vld_q ? data_q : in_data;
        assign req[i]       = (vld_q | lane_done[i]) & (cand_pa[i] != '0);
        assign retire       = gnt[i] | (cand_pa[i] == '0);
        assign in_load      = lane_done[i] & (in_pa != '0);
        assign lane_stall[i] = vld_q;
`ifdef WB_ARB_ERR_CHECK_EN
        assign viol[i] = vld_q & ~retire & lane_done[i];
`endif

        always_comb begin
            vld_d  = vld_q;
            pa_d   = pa_q;
            data_d = data_q;
            if (vld_q) begin
                if (retire) begin
                    vld_d  = in_load;
                    pa_d   = in_pa;
                    data_d = in_data;
                end
            end else if (in_load && !gnt[i]) begin
                vld_d  = 1'b1;
                pa_d   = in_pa;
                data_d = in_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rstn) begin
                vld_q  <= 1'b0;
                pa_q   <= '0;
                data_q <= '0;
            end else begin
                vld_q  <= vld_d;
                pa_q   <= pa_d;
                data_q <= data_d;
            end
        end
    end

    wb_arbiter_rr #(
        .N     (N_LANES),
        .IDX_W (LEN_LANE_IDX)
    ) u_rr (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld)
            rr_ptr_d = (gnt_idx == LEN_LANE_IDX'(N_LANES-1)) ? '0 : gnt_idx + 1'b1;
    end

    logic                     wr_en_q;
    logic [LEN_PREG_ADDR-1:0] wr_pa_q;
    logic [LEN_WORD-1:0]      wr_data_q;
    logic [LEN_LANE_IDX-1:0]  wr_lane_q;

    always_ff @(posedge clk) begin
        if (rstn) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_pa_q   <= '0;
            wr_data_q <= '0;
            wr_lane_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_en_q  <= gnt_vld;
            if (gnt_vld) begin
                wr_pa_q   <= cand_pa[gnt_idx];
                wr_data_q <= cand_data[gnt_idx];
                wr_lane_q <= gnt_idx;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_pa   = wr_pa_q;
    assign wr_data = wr_data_q;
    assign wr_lane = wr_lane_q;

`ifdef WB_ARB_ERR_CHECK_EN
    logic                    err_q;
    logic [LEN_LANE_IDX-1:0] err_lane_q, viol_idx;

    // Lowest violating lane wins when several drop on the same cycle.
    always_comb begin
        viol_idx = '0;
        for (int i = N_LANES - 1; i >= 0; i--)
            if (viol[i]) viol_idx = LEN_LANE_IDX'(i);
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            err_q      <= 1'b0;
            err_lane_q <= '0;
        end else if (|viol && !err_q) begin
            err_q      <= 1'b1;
            err_lane_q <= viol_idx;
        end
    end

    assign err      = err_q;
    assign err_lane = err_lane_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (4 lanes); err checks only with WB_ARB_ERR_CHECK_EN.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  lane_done;
    logic [23:0] lane_pa_rd;
    logic [127:0] lane_rd;
    logic [3:0]  lane_stall;
    logic        wr_en;
    logic [5:0]  wr_pa;
    logic [31:0] wr_data;
    logic [1:0]  wr_lane;
`ifdef WB_ARB_ERR_CHECK_EN
    logic        err;
    logic [1:0]  err_lane;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk        (clk),
        .rstn       (rstn),
        .lane_done  (lane_done),
        .lane_pa_rd (lane_pa_rd),
        .lane_rd    (lane_rd),
        .lane_stall (lane_stall),
        .wr_en      (wr_en),
        .wr_pa      (wr_pa),
        .wr_data    (wr_data),
        .wr_lane    (wr_lane)
`ifdef WB_ARB_ERR_CHECK_EN
        ,
        .err        (err),
        .err_lane   (err_lane)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic [5:0] pa, input logic [31:0] rd);
        lane_done[i]          = 1'b1;
        lane_pa_rd[i*6 +: 6]  = pa;
        lane_rd[i*32 +: 32]   = rd;
    endtask

    task automatic clr();
        lane_done = '0;
    endtask

    task automatic chk_wr(input string tag, input logic [1:0] lane, input logic [5:0] pa,
                          input logic [31:0] data, input logic [3:0] stall);
        chk({tag, ".en"}, wr_en, 1'b1);
        chk({tag, ".lane"}, wr_lane, lane);
        chk({tag, ".pa"}, wr_pa, pa);
        chk({tag, ".data"}, wr_data, data);
        chk({tag, ".stall"}, lane_stall, stall);
    endtask

    initial begin
        rstn = 1'b1; lane_done = '0; lane_pa_rd = '0; lane_rd = '0;
        tick(); tick();
        rstn = 1'b0;
        chk("rst.en", wr_en, 1'b0);
        chk("rst.pa", wr_pa, 6'd0);
        chk("rst.data", wr_data, 32'd0);
        chk("rst.lane", wr_lane, 2'd0);
        chk("rst.stall", lane_stall, 4'b0000);
`ifdef WB_ARB_ERR_CHECK_EN
        chk("rst.err", err, 1'b0);
`endif

        // single lane, immediate grant
        drive(1, 6'd5, 32'hDEADBEEF);
        tick(); clr();
        chk_wr("single", 2'd1, 6'd5, 32'hDEADBEEF, 4'b0000);
        tick();
        chk("single.idle_en", wr_en, 1'b0);
        chk("single.hold_data", wr_data, 32'hDEADBEEF);

        // lane 3 alone brings rr_ptr from 2 to 0
        drive(3, 6'd6, 32'h33);
        tick(); clr();
        chk_wr("ptr0", 2'd3, 6'd6, 32'h33, 4'b0000);

        // all four together
        for (int i = 0; i < 4; i++) drive(i, 6'(i + 1), 32'h100 + i);
        tick(); clr();
        chk_wr("all.0", 2'd0, 6'd1, 32'h100, 4'b1110);
        tick();
        chk_wr("all.1", 2'd1, 6'd2, 32'h101, 4'b1100);
        tick();
        chk_wr("all.2", 2'd2, 6'd3, 32'h102, 4'b1000);
        tick();
        chk_wr("all.3", 2'd3, 6'd4, 32'h103, 4'b0000);
        tick();
        chk("all.idle", wr_en, 1'b0);

        // lane 2 buffered, refilled on the cycle its buffer is granted
        drive(0, 6'd11, 32'hB0); drive(2, 6'd9, 32'h9);
        tick(); clr();
        chk_wr("refill.0", 2'd0, 6'd11, 32'hB0, 4'b0100);
        drive(2, 6'd10, 32'hA);
        tick(); clr();
        chk_wr("refill.9", 2'd2, 6'd9, 32'h9, 4'b0100);
        tick();
        chk_wr("refill.10", 2'd2, 6'd10, 32'hA, 4'b0000);
        tick();
        chk("refill.idle", wr_en, 1'b0);
`ifdef WB_ARB_ERR_CHECK_EN
        chk("refill.noerr", err, 1'b0);
`endif

        // tag 0 retires without a write or a stall
        drive(0, 6'd0, 32'hFFFF); drive(3, 6'd7, 32'h77);
        tick(); clr();
        chk_wr("zero", 2'd3, 6'd7, 32'h77, 4'b0000);
        tick();
        chk("zero.idle", wr_en, 1'b0);
        chk("zero.stall", lane_stall, 4'b0000);

        // lanes 0 and 1 hammering: strict alternation
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                drive(0, 6'd32, 32'd32 * 32'h1000);
                drive(1, 6'd48, 32'd48 * 32'h1000);
            end else if (k % 2 == 1) begin
                drive(0, 6'(32 + (k + 1) / 2), 32'(32 + (k + 1) / 2) * 32'h1000);
            end else begin
                drive(1, 6'(48 + k / 2), 32'(48 + k / 2) * 32'h1000);
            end
            tick(); clr();
            if (k % 2 == 1)
                chk_wr($sformatf("rot.%0d", k), 2'd1, 6'(48 + (k - 1) / 2),
                       32'(48 + (k - 1) / 2) * 32'h1000, 4'b0001);
            else
                chk_wr($sformatf("rot.%0d", k), 2'd0, 6'(32 + k / 2),
                       32'(32 + k / 2) * 32'h1000, 4'b0010);
        end
        tick();
        chk_wr("rot.drain", 2'd0, 6'd35, 32'd35 * 32'h1000, 4'b0000);
        tick();
        chk("rot.idle", wr_en, 1'b0);

        // protocol violation on lane 3: incoming dropped, old entry kept
        drive(1, 6'd41, 32'h41); drive(2, 6'd42, 32'h42); drive(3, 6'd43, 32'h43);
        tick(); clr();
        chk_wr("viol.1", 2'd1, 6'd41, 32'h41, 4'b1100);
        drive(3, 6'd44, 32'h44);
        tick(); clr();
        chk_wr("viol.2", 2'd2, 6'd42, 32'h42, 4'b1000);
`ifdef WB_ARB_ERR_CHECK_EN
        chk("viol.err", err, 1'b1);
        chk("viol.err_lane", err_lane, 2'd3);
`endif
        tick();
        chk_wr("viol.3", 2'd3, 6'd43, 32'h43, 4'b0000);
`ifdef WB_ARB_ERR_CHECK_EN
        chk("viol.sticky", err, 1'b1);
`endif
        tick();
        chk("viol.idle", wr_en, 1'b0);

        // reset discards a buffered entry
        drive(0, 6'd50, 32'h50); drive(1, 6'd51, 32'h51);
        tick(); clr();
        chk_wr("rst2.pre", 2'd0, 6'd50, 32'h50, 4'b0010);
        rstn = 1'b1;
        tick();
        chk("rst2.en", wr_en, 1'b0);
        chk("rst2.pa", wr_pa, 6'd0);
        chk("rst2.data", wr_data, 32'd0);
        chk("rst2.stall", lane_stall, 4'b0000);
`ifdef WB_ARB_ERR_CHECK_EN
        chk("rst2.err", err, 1'b0);
        chk("rst2.err_lane", err_lane, 2'd0);
`endif
        rstn = 1'b0;
        tick();
        chk("rst2.discard", wr_en, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
